// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : shares one single-port memory between IF and MEM stages
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          if_stall_o,
  output logic          d_stall_o,
  output logic          timeout_o
);

  localparam int BCW = $clog2(MAX_D_BURST + 1);
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_D_BURST);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_XFER = 2'd1,
    S_D_XFER  = 2'd2
  } state_t;

  state_t         state_q;
  logic           if_ack_q;
  logic           d_ack_q;
  logic [DW-1:0]  if_rdata_q;
  logic [DW-1:0]  d_rdata_q;
  logic           mem_req_q;
  logic           mem_we_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;
  logic           timeout_q;
  logic [BCW-1:0] burst_cnt_q;
  logic [WCW-1:0] wait_cnt_q;

  logic if_valid;
  logic d_valid;
  logic d_grant;
  logic if_grant;
  logic abort;

  // A requester is still holding its request during its own ack cycle.
  assign if_valid = if_req_i & ~if_ack_q;
  assign d_valid  = d_req_i & ~d_ack_q;
  assign d_grant  = d_valid & (~if_valid | (burst_cnt_q < BURST_MAX));
  assign if_grant = if_valid & ~d_grant;
  assign abort    = (TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      timeout_q   <= 1'b0;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if (!if_req_i) begin
        burst_cnt_q <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (d_grant) begin
            state_q     <= S_D_XFER;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            wait_cnt_q  <= '0;
            if (if_req_i && (burst_cnt_q < BURST_MAX)) begin
              burst_cnt_q <= burst_cnt_q + BCW'(1);
            end
          end else if (if_grant) begin
            state_q     <= S_IF_XFER;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
          end
        end
        S_IF_XFER, S_D_XFER: begin
          // Ready in the last allowed cycle still completes normally.
          if (mem_ready_i) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            if (state_q == S_IF_XFER) begin
              if_rdata_q <= mem_rdata_i;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata_i;
              end
              d_ack_q <= 1'b1;
            end
          end else if (abort) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            timeout_q <= 1'b1;
            if (state_q == S_IF_XFER) begin
              if_rdata_q <= '0;
              if_ack_q   <= 1'b1;
            end else begin
              d_rdata_q <= '0;
              d_ack_q   <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign timeout_o   = timeout_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign d_stall_o   = d_req_i & ~d_ack_q;

endmodule
`default_nettype wire
